// File: rtl/umips_lsu.sv
// umips_lsu: load/store unit between the umips execute stage and a word-addressed data RAM.
// Ports: clk_i/rst_ni clock and async active-low reset; req_i/ready_o request handshake with
// we_i, size_i, uns_i, addr_i, wdata_i; rdata_o/rvalid_o load result, done_o store commit,
// err_o rejected request; ram_we_o/ram_a_o/ram_wd_o/ram_rd_i RAM port (combinational read).
module umips_lsu #(
  parameter int ADDR_W = 14
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        ready_o,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        done_o,
  output logic        err_o,
  output logic        ram_we_o,
  output logic [31:0] ram_a_o,
  output logic [31:0] ram_wd_o,
  input  logic [31:0] ram_rd_i
);
  typedef enum logic {IDLE, RMW_WR} state_e;
  state_e      state_q;
  logic [29:0] addr_q;
  logic [31:0] old_q, rdata_q;
  logic [15:0] wdata_q;
  logic [1:0]  lane_q;
  logic        half_q, rvalid_q, done_q, err_q;
  logic        rmw, acc, bad, ok, ld, word_st, sub_st;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val, mask, rep, merged;
  assign rmw     = state_q == RMW_WR;
  assign ready_o = !rmw;
  assign acc     = req_i && ready_o;
  assign bad     = size_i == 2'b11 || (size_i == 2'b01 && addr_i[0]) ||
                   (size_i == 2'b10 && |addr_i[1:0]) || |addr_i[31:ADDR_W];
  assign ok      = acc && !bad;
  assign ld      = ok && !we_i;
  assign word_st = ok && we_i && size_i == 2'b10;
  assign sub_st  = ok && we_i && size_i != 2'b10;
  assign ld_b    = ram_rd_i[{addr_i[1:0], 3'b000} +: 8];
  assign ld_h    = addr_i[1] ? ram_rd_i[31:16] : ram_rd_i[15:0];
  assign ld_val  = size_i == 2'b00 ? {{24{!uns_i && ld_b[7]}}, ld_b} :
                   size_i == 2'b01 ? {{16{!uns_i && ld_h[15]}}, ld_h} : ram_rd_i;
  // Only the target lanes take the new data; all other bits come from the captured old word.
  assign mask    = half_q ? 32'h0000_FFFF << {lane_q[1], 4'b0000} : 32'h0000_00FF << {lane_q, 3'b000};
  assign rep     = half_q ? {2{wdata_q}} : {4{wdata_q[7:0]}};
  assign merged  = (old_q & ~mask) | (rep & mask);
  // Gating with rst_ni drops the write the moment reset asserts, even mid-RMW.
  assign ram_we_o = rst_ni && (rmw || word_st);
  assign ram_a_o  = rmw ? {addr_q, 2'b00} : {addr_i[31:2], 2'b00};
  assign ram_wd_o = rmw ? merged : wdata_i;
  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      old_q    <= '0;
      wdata_q  <= '0;
      lane_q   <= '0;
      half_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= sub_st ? RMW_WR : IDLE;
      rvalid_q <= ld;
      err_q    <= acc && bad;
      done_q   <= word_st || rmw;
      if (ld) rdata_q <= ld_val;
      if (sub_st) begin
        addr_q  <= addr_i[31:2];
        old_q   <= ram_rd_i;
        wdata_q <= wdata_i[15:0];
        lane_q  <= addr_i[1:0];
        half_q  <= size_i[0];
      end
    end
  end
endmodule

// File: tb/tb_umips_lsu.sv
// tb_umips_lsu: directed self-checking bench for umips_lsu with a behavioural RAM.
module tb_umips_lsu;
  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, rvalid, done, err, ram_we;
  logic [31:0] rdata, ram_a, ram_wd, ram_rd;
  logic [31:0] mem [0:4095];
  int checks = 0, failures = 0;

  umips_lsu #(.ADDR_W(14)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ready_o(ready), .we_i(we), .size_i(size),
    .uns_i(uns), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .rvalid_o(rvalid),
    .done_o(done), .err_o(err), .ram_we_o(ram_we), .ram_a_o(ram_a), .ram_wd_o(ram_wd),
    .ram_rd_i(ram_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ram_we) mem[ram_a[13:2]] <= ram_wd;
  assign ram_rd = mem[ram_a[13:2]];

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
  endtask

  task automatic put_word(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 2'b10, 1'b0, a, d);
    cyc;
    req = 1'b0;
    cyc;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%h exp=1", ready); end
    checks++; if ({rvalid, done, err, ram_we} !== 4'b0) begin failures++; $display("FAIL reset_pulses got=%b exp=0000", {rvalid, done, err, ram_we}); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc;
  endtask

  task automatic test_word;
    drive(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    #1;
    checks++; if (ram_we !== 1'b1 || ram_a !== 32'h100 || ram_wd !== 32'hDEADBEEF) begin failures++; $display("FAIL word_st_ram got=%b/%h/%h exp=1/00000100/deadbeef", ram_we, ram_a, ram_wd); end
    cyc;
    drive(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    #1;
    checks++; if (done !== 1'b1 || rvalid !== 1'b0) begin failures++; $display("FAIL word_st_done got=%b%b exp=10", done, rvalid); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL word_ld_nowe got=%b exp=0", ram_we); end
    cyc;
    req = 1'b0;
    checks++; if (rvalid !== 1'b1 || done !== 1'b0 || rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL word_ld got=%b%b/%h exp=10/deadbeef", rvalid, done, rdata); end
    cyc;
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL word_ld_pulse got=%b exp=0", rvalid); end
  endtask

  task automatic test_byte_rmw;
    put_word(32'h200, 32'h11223344);
    drive(1'b1, 2'b00, 1'b0, 32'h202, 32'hFFFFFFAA);
    #1;
    checks++; if (ready !== 1'b1 || ram_we !== 1'b0) begin failures++; $display("FAIL rmw_t got=%b%b exp=10", ready, ram_we); end
    cyc;
    req = 1'b0;
    #1;
    checks++; if (ready !== 1'b0 || ram_we !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL rmw_t1_ctl got=%b%b%b exp=010", ready, ram_we, done); end
    checks++; if (ram_a !== 32'h200 || ram_wd !== 32'h11AA3344) begin failures++; $display("FAIL rmw_t1_data got=%h/%h exp=00000200/11aa3344", ram_a, ram_wd); end
    cyc;
    checks++; if (done !== 1'b1 || ready !== 1'b1) begin failures++; $display("FAIL rmw_t2 got=%b%b exp=11", done, ready); end
    checks++; if (mem[12'h080] !== 32'h11AA3344) begin failures++; $display("FAIL rmw_mem got=%h exp=11aa3344", mem[12'h080]); end
    cyc;
  endtask

  task automatic test_loads;
    logic [1:0]  sz [4] = '{2'b01, 2'b01, 2'b00, 2'b00};
    logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad [4] = '{32'h42, 32'h42, 32'h41, 32'h40};
    logic [31:0] ex [4] = '{32'hFFFF80F0, 32'h000080F0, 32'h0000007F, 32'h00000001};
    put_word(32'h40, 32'h80F07F01);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, sz[i], un[i], ad[i], 32'h0);
      cyc;
      checks++; if (rvalid !== 1'b1 || rdata !== ex[i]) begin failures++; $display("FAIL load_%0d got=%b/%h exp=1/%h", i, rvalid, rdata, ex[i]); end
    end
    req = 1'b0;
    cyc;
  endtask

  task automatic test_illegal;
    logic        w  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  sz [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] ad [4] = '{32'h203, 32'h102, 32'h40, 32'h4000};
    for (int i = 0; i < 4; i++) begin
      drive(w[i], sz[i], 1'b0, ad[i], 32'h00001234);
      #1;
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL illegal_%0d_we got=%b exp=0", i, ram_we); end
      cyc;
      req = 1'b0;
      checks++; if ({err, rvalid, done} !== 3'b100 || rdata !== 32'h1) begin failures++; $display("FAIL illegal_%0d got=%b/%h exp=100/00000001", i, {err, rvalid, done}, rdata); end
      cyc;
      checks++; if (err !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL illegal_%0d_pulse got=%b%b exp=01", i, err, ready); end
    end
    checks++; if (mem[12'h080] !== 32'h11AA3344 || mem[12'h010] !== 32'h80F07F01) begin failures++; $display("FAIL illegal_mem got=%h/%h exp=11aa3344/80f07f01", mem[12'h080], mem[12'h010]); end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000BEEF);
    cyc;
    drive(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL b2b_t1_ready got=%b exp=0", ready); end
    cyc;
    checks++; if (done !== 1'b1 || rvalid !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL b2b_t2 got=%b%b%b exp=101", done, rvalid, ready); end
    cyc;
    req = 1'b0;
    checks++; if (rvalid !== 1'b1 || done !== 1'b0 || rdata !== 32'hBEEF3344) begin failures++; $display("FAIL b2b_t3 got=%b%b/%h exp=10/beef3344", rvalid, done, rdata); end
    cyc;
  endtask

  task automatic test_reset_rmw;
    put_word(32'h300, 32'h55555555);
    drive(1'b1, 2'b00, 1'b0, 32'h301, 32'h000000AA);
    cyc;
    req = 1'b0;
    checks++; if (ram_we !== 1'b1 || ready !== 1'b0) begin failures++; $display("FAIL rst_rmw_pre got=%b%b exp=10", ram_we, ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL rst_rmw_we got=%b%b exp=01", ram_we, ready); end
    checks++; if ({rvalid, done, err} !== 3'b0 || rdata !== 32'h0) begin failures++; $display("FAIL rst_rmw_out got=%b/%h exp=000/00000000", {rvalid, done, err}, rdata); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc;
    checks++; if (mem[12'h0C0] !== 32'h55555555) begin failures++; $display("FAIL rst_rmw_mem got=%h exp=55555555", mem[12'h0C0]); end
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL rst_rmw_post got=%b%b exp=10", ready, done); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_word;
    test_byte_rmw;
    test_loads;
    test_illegal;
    test_back_to_back;
    test_reset_rmw;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
